// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side inputs (ID/EX operand info, branch
// and data-memory status) and the pipeline control / debug outputs.
//   master : pipeline side, drives *_i, observes *_o
//   slave  : hazard_ctrl, observes *_i, drives *_o
interface hazard_ctrl_if;
  logic [2:0]  id_rs_i;
  logic [2:0]  id_rt_i;
  logic        id_use_rs_i;
  logic        id_use_rt_i;
  logic [2:0]  ex_rd_i;
  logic        ex_memread_i;
  logic        ex_regwrite_i;
  logic        branch_taken_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        PCWrite_o;
  logic        DHZ_o;
  logic        CHZ_o;
  logic        IDEX_flush_o;
  logic        freeze_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rd_i,
           ex_memread_i, ex_regwrite_i, branch_taken_i, mem_req_i, mem_ready_i,
    input  PCWrite_o, DHZ_o, CHZ_o, IDEX_flush_o, freeze_o, state_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rd_i,
           ex_memread_i, ex_regwrite_i, branch_taken_i, mem_req_i, mem_ready_i,
    output PCWrite_o, DHZ_o, CHZ_o, IDEX_flush_o, freeze_o, state_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall insertion, taken-branch flush
// sequencing and whole-pipeline freeze during data-memory wait states, plus
// saturating stall/flush debug counters.
// Ports:
//   clk_i  : clock, rising edge
//   rst_n  : asynchronous reset, active low (forces all controls to 0)
//   bus    : hazard_ctrl_if.slave (ID/EX/MEM status in, pipeline controls out)
// Control outputs are Mealy: decoded from the registered state and the
// current inputs so a hazard is covered in the cycle it is detected.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic         clk_i,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned REM_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam logic [REM_W-1:0] LD_REM = REM_W'(LOAD_LAT - 1);
  localparam logic [REM_W-1:0] FL_REM = REM_W'(FLUSH_CYC - 1);
  localparam bit LD_MULTI = (LOAD_LAT > 1);
  localparam bit FL_MULTI = (FLUSH_CYC > 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e           state_q;
  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic hz;
  logic frz;
  logic rs_match;
  logic rt_match;
  logic pcwrite;
  logic dhz;
  logic chz;
  logic idex_flush;
  logic freeze;

  // Load-use hazard; r0 is hardwired so it never creates a dependency.
  assign rs_match = bus.id_use_rs_i & (bus.id_rs_i == bus.ex_rd_i);
  assign rt_match = bus.id_use_rt_i & (bus.id_rt_i == bus.ex_rd_i);
  assign hz  = bus.ex_memread_i & bus.ex_regwrite_i & (bus.ex_rd_i != 3'd0) &
               (rs_match | rt_match);
  assign frz = bus.mem_req_i & ~bus.mem_ready_i;

  // Control decode, priority: freeze > branch > FLUSH > LDSTALL > RUN.
  always_comb begin
    pcwrite    = 1'b0;
    dhz        = 1'b0;
    chz        = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;
    if (!rst_n) begin
      pcwrite = 1'b0;
    end else if (frz) begin
      freeze = 1'b1;
      dhz    = 1'b1;
    end else if (bus.branch_taken_i) begin
      chz        = 1'b1;
      idex_flush = 1'b1;
      pcwrite    = 1'b1;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          chz        = 1'b1;
          idex_flush = 1'b1;
          pcwrite    = 1'b1;
        end
        ST_LDSTALL: begin
          dhz        = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          if (hz) begin
            dhz        = 1'b1;
            idex_flush = 1'b1;
          end else begin
            pcwrite = 1'b1;
          end
        end
      endcase
    end
  end

  // State, remaining-cycle count and debug counters. A freeze holds the
  // sequence so any pending stall or flush resumes once memory completes.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (dhz && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!frz) begin
        if (bus.branch_taken_i) begin
          if (flush_cnt_q != '1) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
          end
          if (FL_MULTI) begin
            state_q <= ST_FLUSH;
            rem_q   <= FL_REM;
          end else begin
            state_q <= ST_RUN;
            rem_q   <= '0;
          end
        end else begin
          case (state_q)
            ST_FLUSH, ST_LDSTALL: begin
              // rem of 0 cannot occur in a legal sequence; treat it as done.
              if (rem_q <= REM_W'(1)) begin
                state_q <= ST_RUN;
                rem_q   <= '0;
              end else begin
                rem_q <= rem_q - REM_W'(1);
              end
            end
            default: begin
              if (hz && LD_MULTI) begin
                state_q <= ST_LDSTALL;
                rem_q   <= LD_REM;
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.PCWrite_o    = pcwrite;
  assign bus.DHZ_o        = dhz;
  assign bus.CHZ_o        = chz;
  assign bus.IDEX_flush_o = idex_flush;
  assign bus.freeze_o     = freeze;
  assign bus.state_o      = state_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule
